// File: rtl/char_stream_out.sv
// Character streamer: on a start pulse or end-of-program status, reads n characters from a
// synchronous buffer and presents them on a paced valid/ready output with a mid-gap strobe.
module char_stream_out #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH      = 100,
  parameter int unsigned ADDR_W     = $clog2(DEPTH),
  parameter int unsigned STATUS_W   = 36,
  parameter int unsigned DONE_VALUE = 500,
  parameter int unsigned PACE       = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [STATUS_W-1:0] status_in,
  input  logic                start,
  input  logic                clear,
  input  logic                abort,
  input  logic [ADDR_W:0]     len,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0]   rd_data,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                test_strobe,
  output logic                busy,
  output logic                done,
  output logic                end_flag
);

  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam int unsigned CNT_W = (PACE > 0) ? $clog2(PACE + 1) : 1;
  localparam int unsigned HALF  = PACE / 2;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_PRESENT, S_GAP, S_FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    n_q, n_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                armed_q, armed_d;
  logic [ADDR_W-1:0]   rd_addr_d;
  logic [DATA_W-1:0]   out_data_d;
  logic                out_valid_d, test_strobe_d, busy_d, done_d, end_flag_d;
  logic                trig_auto;

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    n_d           = n_q;
    cnt_d         = cnt_q;
    armed_d       = armed_q;
    rd_addr_d     = rd_addr;
    out_data_d    = out_data;
    out_valid_d   = out_valid;
    test_strobe_d = 1'b0;
    busy_d        = busy;
    done_d        = 1'b0;
    end_flag_d    = end_flag;
    trig_auto     = armed_q && (status_in == STATUS_W'(DONE_VALUE));

    if (clear) begin
      end_flag_d = 1'b0;
      armed_d    = 1'b1;
    end

    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start || trig_auto) begin
            end_flag_d = 1'b1;
            if (trig_auto) armed_d = 1'b0;
            n_d       = (len > IDX_W'(DEPTH)) ? IDX_W'(DEPTH) : len;
            idx_d     = '0;
            rd_addr_d = '0;
            if (n_d == '0) begin
              state_d = S_FINISH;
            end else begin
              state_d = S_FETCH;
              busy_d  = 1'b1;
            end
          end
        end
        S_FETCH: begin
          rd_addr_d = ADDR_W'(idx_q);
          state_d   = S_WAIT;
        end
        S_WAIT: begin
          out_data_d  = rd_data;
          out_valid_d = 1'b1;
          state_d     = S_PRESENT;
        end
        S_PRESENT: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            idx_d       = idx_q + IDX_W'(1);
            if (idx_q == n_q - IDX_W'(1)) begin
              state_d = S_FINISH;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              // Address the next character early so a registered buffer has it by WAIT
              rd_addr_d = ADDR_W'(idx_q + IDX_W'(1));
              if (PACE == 0) begin
                state_d = S_FETCH;
              end else begin
                state_d       = S_GAP;
                cnt_d         = '0;
                test_strobe_d = (HALF == 0);
              end
            end
          end
        end
        S_GAP: begin
          if (cnt_q == CNT_W'(PACE - 1)) begin
            state_d = S_FETCH;
          end else begin
            cnt_d         = cnt_q + CNT_W'(1);
            test_strobe_d = (cnt_d == CNT_W'(HALF));
          end
        end
        S_FINISH: begin
          // Streams pulse done on the last transfer; an empty stream pulses it here
          done_d  = !done;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      n_q         <= '0;
      cnt_q       <= '0;
      armed_q     <= 1'b1;
      rd_addr     <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      test_strobe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      end_flag    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      rd_addr     <= rd_addr_d;
      out_data    <= out_data_d;
      out_valid   <= out_valid_d;
      test_strobe <= test_strobe_d;
      busy        <= busy_d;
      done        <= done_d;
      end_flag    <= end_flag_d;
    end
  end

endmodule

// File: tb/tb_char_stream_out.sv
// Bench for char_stream_out: randomized buffers and back-pressure against a queue-based model.
module tb_char_stream_out;
  localparam int unsigned DATA_W = 8, DEPTH = 100, ADDR_W = $clog2(DEPTH);
  localparam int unsigned STATUS_W = 36, DONE_VALUE = 500, PACE = 10;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic [STATUS_W-1:0] status_in = '0;
  logic                start = 1'b0, clear = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic [ADDR_W:0]     len = '0;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   rd_data = '0;
  logic [DATA_W-1:0]   out_data;
  logic                out_valid, test_strobe, busy, done, end_flag;

  char_stream_out dut (
    .clock(clock), .reset(reset), .status_in(status_in), .start(start), .clear(clear),
    .abort(abort), .len(len), .rd_addr(rd_addr), .rd_data(rd_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .test_strobe(test_strobe), .busy(busy),
    .done(done), .end_flag(end_flag)
  );

  always #5 clock = ~clock;

  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clock) if (int'(rd_addr) < DEPTH) rd_data <= mem[rd_addr];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0, n_errors = 0;
  int trig_cyc;

  // Transfer log gathered away from the clock edge
  logic [DATA_W-1:0] acc_data[$];
  int acc_cyc[$], strb_cyc[$];
  int done_cnt = 0, done_cyc = -1, stab_err = 0;
  bit p_hold = 0;
  logic [DATA_W-1:0] p_data;

  always @(negedge clock) begin
    if (reset) begin
      if (p_hold && !(out_valid && out_data == p_data)) stab_err++;
      if (out_valid && out_ready && !abort) begin
        acc_data.push_back(out_data);
        acc_cyc.push_back(cyc);
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (test_strobe) strb_cyc.push_back(cyc);
      p_hold = out_valid && !out_ready && !abort;
      p_data = out_data;
    end else begin
      p_hold = 0;
    end
  end

  task automatic tick(); @(posedge clock); #1; endtask

  task automatic clear_log();
    acc_data.delete(); acc_cyc.delete(); strb_cyc.delete();
    done_cnt = 0; done_cyc = -1; stab_err = 0;
  endtask

  task automatic fill_mem(input bit alpha);
    for (int i = 0; i < DEPTH; i++) mem[i] = alpha ? DATA_W'(65 + i % 26) : DATA_W'($urandom);
  endtask

  task automatic trigger_start(input int l);
    len = (ADDR_W+1)'(l); start = 1'b1; trig_cyc = cyc; tick(); start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      if (done_cnt > 0) begin ok = 1; break; end
      tick();
    end
  endtask

  // Model: a stream of length l yields buffer entries 0..min(l,DEPTH)-1 in order
  task automatic check_stream(input string name, input int l);
    int n = (l > DEPTH) ? DEPTH : l;
    n_checks++;
    if (acc_data.size() !== n) begin
      n_errors++; $display("FAIL %s_count: got %0d expected %0d", name, acc_data.size(), n);
    end
    for (int i = 0; i < n && i < acc_data.size(); i++) begin
      n_checks++;
      if (acc_data[i] !== mem[i]) begin
        n_errors++; $display("FAIL %s_char%0d: got %0h expected %0h", name, i, acc_data[i], mem[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; #12;
    n_checks++;
    if ({rd_addr, out_data, out_valid, test_strobe, busy, done, end_flag} !== '0) begin
      n_errors++; $display("FAIL reset_outputs: got %0h expected 0",
        {rd_addr, out_data, out_valid, test_strobe, busy, done, end_flag});
    end
    tick(); reset = 1'b1; tick(); tick();
    n_checks++;
    if ({out_valid, busy, end_flag} !== 3'b000) begin
      n_errors++; $display("FAIL reset_idle: got %0b expected 000", {out_valid, busy, end_flag});
    end
  endtask

  task automatic test_auto_stream();
    bit ok;
    clear_log(); fill_mem(1'b1); len = (ADDR_W+1)'(100); out_ready = 1'b1;
    tick(); status_in = STATUS_W'(DONE_VALUE); trig_cyc = cyc; tick();
    wait_done(2500, ok); tick();
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL auto_timeout: got 0 expected 1"); end
    check_stream("auto", 100);
    n_checks++;
    if (acc_cyc.size() > 0 && acc_cyc[0] !== trig_cyc + 3) begin
      n_errors++; $display("FAIL auto_first_latency: got %0d expected %0d", acc_cyc[0], trig_cyc + 3);
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      n_checks++;
      if (acc_cyc[i] - acc_cyc[i-1] !== PACE + 3) begin
        n_errors++; $display("FAIL auto_spacing%0d: got %0d expected %0d", i, acc_cyc[i] - acc_cyc[i-1], PACE + 3);
      end
    end
    n_checks++;
    if (strb_cyc.size() !== 99) begin
      n_errors++; $display("FAIL auto_strobe_count: got %0d expected 99", strb_cyc.size());
    end
    for (int i = 0; i < strb_cyc.size() && i < acc_cyc.size(); i++) begin
      n_checks++;
      if (strb_cyc[i] !== acc_cyc[i] + 1 + PACE / 2) begin
        n_errors++; $display("FAIL auto_strobe_pos%0d: got %0d expected %0d", i, strb_cyc[i], acc_cyc[i] + 1 + PACE / 2);
      end
    end
    n_checks++;
    if (acc_cyc.size() > 0 && done_cyc !== acc_cyc[acc_cyc.size()-1] + 1) begin
      n_errors++; $display("FAIL auto_done_time: got %0d expected %0d", done_cyc, acc_cyc[acc_cyc.size()-1] + 1);
    end
    n_checks++;
    if ({done_cnt[3:0], end_flag, busy} !== {4'd1, 1'b1, 1'b0}) begin
      n_errors++; $display("FAIL auto_final: got done_cnt=%0d end_flag=%0b busy=%0b expected 1 1 0", done_cnt, end_flag, busy);
    end
  endtask

  task automatic test_no_rearm();
    bit ok;
    int l = $urandom_range(1, 8);
    clear_log();
    repeat (40) tick();
    n_checks++;
    if (acc_data.size() !== 0 || busy !== 1'b0 || end_flag !== 1'b1) begin
      n_errors++; $display("FAIL rearm_hold: got acc=%0d busy=%0b end_flag=%0b expected 0 0 1", acc_data.size(), busy, end_flag);
    end
    fill_mem(1'b0); len = (ADDR_W+1)'(l);
    clear = 1'b1; tick(); clear = 1'b0;
    n_checks++;
    if (end_flag !== 1'b0) begin n_errors++; $display("FAIL rearm_clear: got %0b expected 0", end_flag); end
    trig_cyc = cyc; tick(); status_in = '0;
    wait_done(600, ok); tick();
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL rearm_timeout: got 0 expected 1"); end
    check_stream("rearm", l);
    n_checks++;
    if (acc_cyc.size() > 0 && acc_cyc[0] !== trig_cyc + 3) begin
      n_errors++; $display("FAIL rearm_latency: got %0d expected %0d", acc_cyc[0], trig_cyc + 3);
    end
    n_checks++;
    if (end_flag !== 1'b1) begin n_errors++; $display("FAIL rearm_flag: got %0b expected 1", end_flag); end
  endtask

  task automatic test_backpressure();
    for (int r = 0; r < 4; r++) begin
      int l = (r == 0) ? 5 : $urandom_range(1, 12);
      bit ok = 0;
      clear_log(); fill_mem(1'b0);
      trigger_start(l);
      for (int k = 0; k < 1500; k++) begin
        if (done_cnt > 0) begin ok = 1; break; end
        out_ready = (r == 0) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
        tick();
      end
      out_ready = 1'b1; tick();
      n_checks++;
      if (!ok) begin n_errors++; $display("FAIL bp%0d_timeout: got 0 expected 1", r); end
      check_stream($sformatf("bp%0d", r), l);
      n_checks++;
      if (stab_err !== 0) begin n_errors++; $display("FAIL bp%0d_stable: got %0d expected 0", r, stab_err); end
      n_checks++;
      if (done_cnt !== 1) begin n_errors++; $display("FAIL bp%0d_done: got %0d expected 1", r, done_cnt); end
    end
  endtask

  task automatic test_len_bounds();
    bit ok;
    clear_log(); out_ready = 1'b1;
    trigger_start(0);
    repeat (8) tick();
    n_checks++;
    if (acc_data.size() !== 0 || done_cnt !== 1) begin
      n_errors++; $display("FAIL len0_counts: got acc=%0d done=%0d expected 0 1", acc_data.size(), done_cnt);
    end
    n_checks++;
    if (done_cyc !== trig_cyc + 2) begin
      n_errors++; $display("FAIL len0_done_time: got %0d expected %0d", done_cyc, trig_cyc + 2);
    end
    clear_log(); fill_mem(1'b0);
    trigger_start(150);
    wait_done(2500, ok); repeat (20) tick();
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL len150_timeout: got 0 expected 1"); end
    check_stream("len150", 150);
  endtask

  task automatic test_abort();
    bit seen = 0;
    clear_log(); fill_mem(1'b0); out_ready = 1'b1;
    trigger_start(10);
    for (int k = 0; k < 300; k++) begin
      tick();
      if (acc_data.size() >= 3) begin
        out_ready = 1'b0;
        if (out_valid) begin seen = 1; break; end
      end
    end
    n_checks++;
    if (!seen || out_data !== mem[3]) begin
      n_errors++; $display("FAIL abort_present: got seen=%0b data=%0h expected 1 %0h", seen, out_data, mem[3]);
    end
    abort = 1'b1; out_ready = 1'b1; tick(); abort = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL abort_stop: got valid=%0b busy=%0b expected 0 0", out_valid, busy);
    end
    out_ready = 1'b1;
    repeat (20) tick();
    n_checks++;
    if (done_cnt !== 0 || acc_data.size() !== 3 || end_flag !== 1'b1) begin
      n_errors++; $display("FAIL abort_after: got done=%0d acc=%0d end_flag=%0b expected 0 3 1", done_cnt, acc_data.size(), end_flag);
    end
  endtask

  task automatic test_reset_midgap();
    bit ok;
    clear_log(); fill_mem(1'b0); out_ready = 1'b1;
    trigger_start(10);
    for (int k = 0; k < 300 && acc_data.size() < 2; k++) tick();
    repeat (3) tick();
    #2 reset = 1'b0; #1;
    n_checks++;
    if ({rd_addr, out_data, out_valid, test_strobe, busy, done, end_flag} !== '0) begin
      n_errors++; $display("FAIL midgap_reset: got %0h expected 0",
        {rd_addr, out_data, out_valid, test_strobe, busy, done, end_flag});
    end
    tick(); tick(); reset = 1'b1; tick();
    clear_log();
    trigger_start(4);
    wait_done(600, ok); tick();
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL midgap_timeout: got 0 expected 1"); end
    check_stream("midgap_restart", 4);
  endtask

  initial begin
    test_reset();
    test_auto_stream();
    test_no_rearm();
    test_backpressure();
    test_len_bounds();
    test_abort();
    test_reset_midgap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/char_stream_out.md
# char_stream_out

Parametrised result/character streamer for the processor top level. It watches the core's status word for the end-of-program marker or accepts an explicit start pulse. It then reads a programmable number of characters from the core's character buffer through a synchronous read port. Characters are presented one at a time on a valid/ready output with a configurable inter-character gap and a mid-gap test strobe, so the top level can drive slow displays or UART-style sinks.

## Interface

- DATA_W, 8, character width
- DEPTH, 100, character buffer depth (entries)
- ADDR_W, $clog2(DEPTH), buffer address width
- STATUS_W, 36, width of core status word
- DONE_VALUE, 500, status value that marks end of program
- PACE, 10, idle cycles between accepted characters (0 allowed)

- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; forces reset state immediately
- status_in  in  STATUS_W  core status/result word
- start  in  1  single-cycle manual trigger
- clear  in  1  clears end_flag and re-arms auto trigger
- abort  in  1  stops an active stream
- len  in  ADDR_W+1  characters to send, sampled at trigger
- rd_addr  out  ADDR_W  buffer read address
- rd_data  in  DATA_W  buffer data, valid 1 cycle after rd_addr
- out_data  out  DATA_W  current character
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts out_data
- test_strobe  out  1  one-cycle pulse at gap midpoint
- busy  out  1  stream in progress
- done  out  1  one-cycle pulse after last character accepted
- end_flag  out  1  sticky: trigger seen

## Operation

- States: IDLE, FETCH, WAIT, PRESENT, GAP, FINISH.
- Reset values: state IDLE, idx 0, rd_addr 0, out_data 0, out_valid 0, test_strobe 0, busy 0, done 0, end_flag 0, armed 1.
- Trigger = start OR (armed AND status_in == DONE_VALUE), examined only in IDLE. Trigger while not IDLE is ignored.
- On trigger: end_flag<=1; an auto trigger also clears armed. Latch n = min(len, DEPTH) and set idx<=0. If n==0, go to FINISH; otherwise go to FETCH with busy<=1.
- FETCH: rd_addr<=idx; go to WAIT.
- WAIT: out_data<=rd_data, out_valid<=1; go to PRESENT.
- PRESENT: hold out_data/out_valid stable until out_ready. On transfer, out_valid<=0 and idx<=idx+1.
  - If idx==n-1, go to FINISH.
  - Else if PACE==0, go to FETCH.
  - Else go to GAP with gap counter cleared.
- GAP: count PACE cycles, then go to FETCH. test_strobe is high for exactly the cycle where count==PACE/2 (integer division).
- FINISH: done pulse for one cycle, busy<=0, then IDLE. end_flag stays set.
- clear: end_flag<=0, armed<=1. It is effective in any state and does not affect an active stream.
- abort (any non-IDLE state): next state IDLE, out_valid<=0, busy<=0, no done pulse. abort has priority over transfer in the same cycle. end_flag is unchanged.
- Simultaneous start and auto match in IDLE count as one trigger; armed is still cleared.
- Counters: idx is ADDR_W+1 bits and never wraps because n<=DEPTH. The gap counter is $clog2(PACE+1) bits.

## Timing

- Trigger cycle T. FETCH is at T+1, WAIT at T+2, and out_valid is high from T+3.
- Transfer at cycle X, PACE>0: next out_valid is at X+PACE+3.
- Transfer at cycle X, PACE==0: next out_valid is at X+3.
- Character i is presented on out_data exactly as rd_data at address i. No reordering and no drops under back-pressure.
- done is asserted the cycle after the last transfer. busy falls in the same cycle.
- Reset assertion drops all outputs asynchronously. Deassertion takes effect at the next clock edge.

## Test plan

- Buffer 0..99 = ASCII 'A'+i%26, len=100, PACE=10, out_ready=1, then status_in=500 -> 100 characters in order, 13-cycle spacing, one test_strobe per gap, end_flag=1, single done.
- status_in held at 500 after completion -> no second stream until clear pulses; after clear -> stream restarts.
- len=5, out_ready toggling 1-of-3 cycles -> out_data stable while waiting, 5 characters accepted, no duplicates.
- len=0 start -> no out_valid, done pulse at T+2; len=150 -> exactly 100 characters.
- abort asserted while presenting character 3 (out_ready=0) -> IDLE next cycle, out_valid=0, no done, end_flag=1.
- reset pulled low mid-GAP -> all outputs 0 immediately; after release, start -> stream begins from character 0.
